// File: rtl/par_sng_lanes.sv
// Parallel binary-to-stochastic generator.
// Each accepted magnitude becomes a 2^WIDTH-bit stream, LANES bits per beat.
// The stream holds exactly that many ones, spread in bit-reversed index order.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready=1, no beats presented
// RUN   | presenting beats; cnt selects the beat, value sets density
module par_sng_lanes #(
  parameter int WIDTH = 8,
  parameter int LANES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_value,
  output logic [LANES-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             sat
);

  localparam int BEATS = (1 << WIDTH) / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LB    = $clog2(LANES);

  localparam logic [WIDTH:0]  FULL     = {1'b1, {WIDTH{1'b0}}};
  localparam logic [CW-1:0]   LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   value;

  logic [WIDTH:0]   value_clamped;
  logic             value_sat;
  logic [WIDTH-1:0] beat_base;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++) begin
      r[j] = x[WIDTH-1-j];
    end
    return r;
  endfunction

  assign value_sat     = (in_value > FULL);
  assign value_clamped = value_sat ? FULL : in_value;

  // Index of lane 0 in the current beat; lanes fill the low LB bits.
  assign beat_base = WIDTH'(cnt) << LB;

  assign out_valid = (state == RUN);
  assign out_last  = (state == RUN) && (cnt == LAST_CNT);
  // A new value can be taken on the last-beat transfer so streams chain without a bubble.
  assign in_ready  = (state == IDLE) || ((state == RUN) && out_last && out_ready);

  // Beat bits: lane set when the bit-reversed stream index falls below the stored value.
  always_comb begin
    data_out = '0;
    if (state == RUN) begin
      for (int i = 0; i < LANES; i++) begin
        data_out[i] = ({1'b0, bit_rev(beat_base + WIDTH'(i))} < value);
      end
    end
  end

  // Sequencer: load on accept, advance the beat counter on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      value <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value <= value_clamped;
            sat   <= value_sat;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (out_last) begin
              cnt <= '0;
              if (in_valid) begin
                value <= value_clamped;
                sat   <= value_sat;
              end else begin
                sat   <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          sat   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_par_sng_lanes.sv
// Directed bench for par_sng_lanes with WIDTH=8, LANES=8 (32 beats per stream).
module tb_par_sng_lanes;

  localparam int BEATS = 32;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_value;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       sat;

  int checks   = 0;
  int failures = 0;

  logic [7:0] bd [64];

  par_sng_lanes #(.WIDTH(8), .LANES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one stream (optionally launching it) and gathers what the DUT presented.
  task automatic run_stream(input bit launch, input logic [8:0] val, input bit stall,
                            input bit chain, input logic [8:0] next_val,
                            output int ones, output int beats, output int cycles,
                            output int bad_last, output int unstable, output int sat_cnt,
                            output bit rdy_last);
    logic [7:0] held;
    bit was_stalled;
    bit done;
    ones = 0; beats = 0; cycles = 0; bad_last = 0; unstable = 0; sat_cnt = 0;
    rdy_last = 1'b0; held = '0; was_stalled = 1'b0; done = 1'b0;
    if (launch) begin
      in_valid  = 1'b1;
      in_value  = val;
      out_ready = 1'b1;
    end
    while (!done && cycles < 300) begin
      cyc();
      in_valid  = 1'b0;
      in_value  = '0;
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      cycles++;
      if (out_valid !== 1'b1) unstable++;
      if (was_stalled && data_out !== held) unstable++;
      if (sat) sat_cnt++;
      if (out_last !== (beats == BEATS - 1)) bad_last++;
      if (out_ready) begin
        ones += $countones(data_out);
        if (beats < 64) bd[beats] = data_out;
        beats++;
        was_stalled = 1'b0;
        if (out_last) begin
          done = 1'b1;
          if (chain) begin
            in_valid = 1'b1;
            in_value = next_val;
          end
          #1;
          rdy_last = in_ready;
        end
      end else begin
        was_stalled = 1'b1;
        held = data_out;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b want=0", sat); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data_out); end
    rst = 1'b0;
    cyc(); cyc();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_hold_valid got=%b want=0", out_valid); end
  endtask

  task automatic test_half();
    int ones, beats, cycles, bad_last, unstable, sat_cnt, bad_data;
    bit rl;
    run_stream(1'b1, 9'd128, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    bad_data = 0;
    for (int b = 0; b < BEATS; b++) if (bd[b] !== 8'h55) bad_data++;
    checks++; if (beats != 32) begin failures++; $display("FAIL half_beats got=%0d want=32", beats); end
    checks++; if (cycles != 32) begin failures++; $display("FAIL half_cycles got=%0d want=32", cycles); end
    checks++; if (bad_data != 0) begin failures++; $display("FAIL half_data bad_beats=%0d want=0 (each 55)", bad_data); end
    checks++; if (bad_last != 0) begin failures++; $display("FAIL half_last bad=%0d want=0", bad_last); end
    checks++; if (sat_cnt != 0) begin failures++; $display("FAIL half_sat got=%0d want=0", sat_cnt); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL half_valid bad=%0d want=0", unstable); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL half_ready_on_last got=%b want=1", rl); end
    cyc(); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL half_back_idle valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_patterns();
    int ones, beats, cycles, bad_last, unstable, sat_cnt, bad_data;
    bit rl;
    run_stream(1'b1, 9'd1, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    bad_data = 0;
    for (int b = 1; b < BEATS; b++) if (bd[b] !== 8'h00) bad_data++;
    checks++; if (bd[0] !== 8'h01) begin failures++; $display("FAIL one_beat0 got=%h want=01", bd[0]); end
    checks++; if (bad_data != 0 || beats != 32) begin failures++; $display("FAIL one_rest bad=%0d beats=%0d want 0/32", bad_data, beats); end
    cyc();
    run_stream(1'b1, 9'd0, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    checks++; if (ones != 0 || beats != 32) begin failures++; $display("FAIL zero_stream ones=%0d beats=%0d want 0/32", ones, beats); end
    checks++; if (bad_last != 0) begin failures++; $display("FAIL zero_last bad=%0d want=0", bad_last); end
    cyc();
    run_stream(1'b1, 9'd256, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    bad_data = 0;
    for (int b = 0; b < BEATS; b++) if (bd[b] !== 8'hFF) bad_data++;
    checks++; if (bad_data != 0 || beats != 32) begin failures++; $display("FAIL full_stream bad=%0d beats=%0d want 0/32", bad_data, beats); end
    checks++; if (sat_cnt != 0) begin failures++; $display("FAIL full_sat got=%0d want=0", sat_cnt); end
    cyc();
  endtask

  task automatic test_sat();
    int ones, beats, cycles, bad_last, unstable, sat_cnt, bad_data;
    bit rl;
    run_stream(1'b1, 9'd300, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    bad_data = 0;
    for (int b = 0; b < BEATS; b++) if (bd[b] !== 8'hFF) bad_data++;
    checks++; if (sat_cnt != 32) begin failures++; $display("FAIL sat_during got=%0d want=32", sat_cnt); end
    checks++; if (bad_data != 0 || ones != 256) begin failures++; $display("FAIL sat_data bad=%0d ones=%0d want 0/256", bad_data, ones); end
    cyc(); #1;
    checks++; if (sat !== 1'b0) begin failures++; $display("FAIL sat_cleared got=%b want=0", sat); end
  endtask

  task automatic test_stall();
    int ones, beats, cycles, bad_last, unstable, sat_cnt;
    bit rl;
    run_stream(1'b1, 9'd77, 1'b1, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    checks++; if (ones != 77) begin failures++; $display("FAIL stall_count got=%0d want=77", ones); end
    checks++; if (beats != 32) begin failures++; $display("FAIL stall_beats got=%0d want=32", beats); end
    checks++; if (unstable != 0) begin failures++; $display("FAIL stall_stable bad=%0d want=0", unstable); end
    checks++; if (bad_last != 0) begin failures++; $display("FAIL stall_last bad=%0d want=0", bad_last); end
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    int ones, beats, cycles, bad_last, unstable, sat_cnt;
    bit rl;
    run_stream(1'b1, 9'd200, 1'b0, 1'b1, 9'd13, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    checks++; if (ones != 200 || beats != 32) begin failures++; $display("FAIL b2b_first ones=%0d beats=%0d want 200/32", ones, beats); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL b2b_ready_on_last got=%b want=1", rl); end
    run_stream(1'b0, 9'd0, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    checks++; if (ones != 13 || beats != 32) begin failures++; $display("FAIL b2b_second ones=%0d beats=%0d want 13/32", ones, beats); end
    checks++; if (cycles != 32 || unstable != 0) begin failures++; $display("FAIL b2b_gap cycles=%0d gaps=%0d want 32/0", cycles, unstable); end
    checks++; if (bad_last != 0) begin failures++; $display("FAIL b2b_last bad=%0d want=0", bad_last); end
    cyc();
  endtask

  task automatic test_reset_midstream();
    int ones, beats, cycles, bad_last, unstable, sat_cnt;
    bit rl;
    in_valid  = 1'b1;
    in_value  = 9'd300;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_value = '0;
    for (int b = 0; b < 10; b++) cyc();
    #1;
    checks++; if (out_valid !== 1'b1 || sat !== 1'b1) begin failures++; $display("FAIL mid_before valid=%b sat=%b want 1/1", out_valid, sat); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_reset valid=%b ready=%b want 0/1", out_valid, in_ready); end
    checks++; if (sat !== 1'b0 || out_last !== 1'b0 || data_out !== 8'h00) begin failures++; $display("FAIL mid_reset_outs sat=%b last=%b data=%h want 0/0/00", sat, out_last, data_out); end
    run_stream(1'b1, 9'd5, 1'b0, 1'b0, 9'd0, ones, beats, cycles, bad_last, unstable, sat_cnt, rl);
    checks++; if (ones != 5 || beats != 32) begin failures++; $display("FAIL mid_restart ones=%0d beats=%0d want 5/32", ones, beats); end
    checks++; if (bad_last != 0 || unstable != 0) begin failures++; $display("FAIL mid_restart_frame last=%0d valid=%0d want 0/0", bad_last, unstable); end
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    test_reset();
    test_half();
    test_patterns();
    test_sat();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
